ifmem_arb: RTL
==============

Name: ifmem_arb

Overview:
Fetch sequencer and single-port memory arbiter for the stage-1 instruction fetch path. It owns the fetch PC and shares one synchronous memory port between instruction fetch and data accesses from the memory stage. It drives the IF stage's ia_valid/pc pair so that each instruction word returning from memory is tagged with its address. It also handles branch redirects, pipeline stalls, fetch halt, and data-burst fairness.

Parameters:
ADDR_W, 24, address width; equals `SIZE_ADDR.
DATA_W, 24, data width; equals `SIZE_DATA.
RESET_PC, 0, first fetch address after reset.
MAX_BURST, 4, maximum consecutive data grants while a fetch is pending (range 1..15).

Ports:
iw_clk  in  1  clock, rising edge
iw_rst_n  in  1  asynchronous active-low reset
iw_stall  in  1  downstream cannot accept a fetched instruction this cycle
iw_halt  in  1  stop fetching; sticky until reset
iw_branch_taken  in  1  redirect fetch this cycle
iw_branch_pc  in  ADDR_W  redirect target
iw_dm_req  in  1  data access request, held until granted
iw_dm_we  in  1  1=write, 0=read
iw_dm_addr  in  ADDR_W  data address
iw_dm_wdata  in  DATA_W  write data
ow_dm_grant  out  1  data access issued this cycle (combinational)
ow_dm_rvalid  out  1  iw_mem_data holds the read data for the granted read
ow_mem_en  out  1  memory port enable
ow_mem_we  out  1  memory write enable
ow_mem_addr  out  ADDR_W  memory address
ow_mem_wdata  out  DATA_W  memory write data
ow_ia_valid  out  1  to IF stage: iw_mem_data is a valid instruction
ow_pc  out  ADDR_W  to IF stage: address of that instruction

Behaviour:
- Memory read latency is 1 cycle: data for an address issued in cycle N appears on iw_mem_data in cycle N+1.
- States: RUN and HALT. Reset state is RUN. Transition RUN->HALT when iw_halt=1. HALT is left only by reset.
- Registers: r_pc (next fetch address), r_if (fetch in flight), r_if_pc, r_dm_rd (read in flight), r_cnt (consecutive data grants).
- Reset values: r_pc=RESET_PC; r_if=0; r_if_pc=0; r_dm_rd=0; r_cnt=0.
- While iw_rst_n=0, all outputs are 0 (combinational outputs gated).
- fetch_want = state==RUN & !iw_halt & !iw_stall.
- Slot choice each cycle:
  - Data slot: when iw_dm_req & (!fetch_want | r_cnt<MAX_BURST).
  - Otherwise fetch slot: when fetch_want.
  - Otherwise idle.
- Data slot:
  - ow_mem_en=1; ow_mem_we=iw_dm_we; ow_mem_addr=iw_dm_addr; ow_mem_wdata=iw_dm_wdata; ow_dm_grant=1.
  - r_dm_rd<=!iw_dm_we.
  - r_cnt<=r_cnt+1 if fetch_want, saturating at MAX_BURST; else 0.
- Fetch slot:
  - ow_mem_en=1; ow_mem_we=0.
  - ow_mem_addr=iw_branch_taken ? iw_branch_pc : r_pc.
  - r_if<=1; r_if_pc<=ow_mem_addr; r_pc<=ow_mem_addr+1 (wraps mod 2^ADDR_W); r_cnt<=0.
- Idle slot: ow_mem_en=0; r_cnt<=0.
- In any non-fetch slot, r_if<=0.
- Outputs to IF stage:
  - ow_pc=r_if_pc.
  - ow_ia_valid=r_if & !iw_branch_taken & !iw_stall & state==RUN & !iw_halt.
- ow_dm_rvalid=r_dm_rd. r_dm_rd clears in any non-data-read slot.
  - ow_ia_valid and ow_dm_rvalid are never both 1.
- Branch (priority over stall):
  - The returning in-flight fetch is squashed.
  - r_pc<=iw_branch_pc when no fetch slot is taken, or iw_branch_pc+1 when a fetch is issued.
  - Branch during a data slot: the redirect is still captured in r_pc.
- Stall with no branch: no fetch issued.
  - If r_if=1, the returned word is dropped and r_pc<=r_if_pc (refetch).
  - Otherwise r_pc holds.
- Halt: the in-flight fetch is dropped and no further fetches are issued. Data slots continue to be served.
- Reset mid-operation clears all in-flight state immediately; no grant or valid is produced.

Test Plan:
- Reset release, RESET_PC=0x10, no requests -> mem_addr 0x10,0x11,0x12 on consecutive cycles; ow_ia_valid=1 with ow_pc 0x10,0x11 one cycle later.
- iw_branch_taken=1, iw_branch_pc=0x200 while fetching 0x13 -> mem_addr=0x200 that cycle; returning word for 0x12 squashed (ia_valid=0); next cycle ow_pc=0x200, r_pc=0x201.
- iw_stall=1 for 2 cycles with fetch of 0x20 in flight -> ia_valid=0, mem_en=0 during stall; after release, refetch 0x20 and deliver ow_pc=0x20.
- iw_dm_req held for 10 cycles, MAX_BURST=4, reads to 0x400 -> grant pattern 4 data, 1 fetch, repeating; ow_dm_rvalid one cycle after each read grant; never coincident with ia_valid.
- iw_dm_we=1 write 0x300<-0xABCDEF -> mem_en=1, mem_we=1, mem_addr=0x300, mem_wdata=0xABCDEF; ow_dm_rvalid stays 0.
- iw_halt pulse, then a data request, then reset low mid-read -> no fetches after halt; data still granted; all outputs 0 immediately on reset; RUN resumes at RESET_PC.

Source files
------------

// File: rtl/ifmem_arb.sv
// Fetch sequencer and single-port memory arbiter for the stage-1 fetch path.
// Owns the fetch PC and shares one synchronous memory port between fetch and data.
module ifmem_arb #(
    parameter int unsigned            ADDR_W    = 24,
    parameter int unsigned            DATA_W    = 24,
    parameter logic [ADDR_W-1:0]      RESET_PC  = '0,
    parameter int unsigned            MAX_BURST = 4
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_stall,
    input  logic              iw_halt,
    input  logic              iw_branch_taken,
    input  logic [ADDR_W-1:0] iw_branch_pc,
    input  logic              iw_dm_req,
    input  logic              iw_dm_we,
    input  logic [ADDR_W-1:0] iw_dm_addr,
    input  logic [DATA_W-1:0] iw_dm_wdata,
    output logic              ow_dm_grant,
    output logic              ow_dm_rvalid,
    output logic              ow_mem_en,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    output logic              ow_ia_valid,
    output logic [ADDR_W-1:0] ow_pc
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic [0:0]        state;
    logic [0:0]        nxt_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] nxt_pc;
    logic              r_if;
    logic [ADDR_W-1:0] r_if_pc;
    logic [ADDR_W-1:0] nxt_if_pc;
    logic              r_dm_rd;
    logic [3:0]        r_cnt;
    logic [3:0]        nxt_cnt;

    logic              fetch_want;
    logic              data_slot;
    logic              fetch_slot;
    logic [ADDR_W-1:0] fetch_addr;

    // Slot decode is gated by reset so no grant or enable escapes while held in reset.
    assign fetch_want = (state == ST_RUN) && !iw_halt && !iw_stall;
    assign data_slot  = iw_rst_n && iw_dm_req && (!fetch_want || (r_cnt < BURST_LIMIT));
    assign fetch_slot = iw_rst_n && !data_slot && fetch_want;
    assign fetch_addr = iw_branch_taken ? iw_branch_pc : r_pc;

    always_comb begin
        ow_mem_en    = 1'b0;
        ow_mem_we    = 1'b0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        ow_dm_grant  = 1'b0;
        if (data_slot) begin
            ow_mem_en    = 1'b1;
            ow_mem_we    = iw_dm_we;
            ow_mem_addr  = iw_dm_addr;
            ow_mem_wdata = iw_dm_wdata;
            ow_dm_grant  = 1'b1;
        end else if (fetch_slot) begin
            ow_mem_en   = 1'b1;
            ow_mem_addr = fetch_addr;
        end
    end

    assign ow_pc        = iw_rst_n ? r_if_pc : '0;
    assign ow_dm_rvalid = iw_rst_n && r_dm_rd;
    assign ow_ia_valid  = iw_rst_n && r_if && !iw_branch_taken && !iw_stall
                          && (state == ST_RUN) && !iw_halt;

    // A stalled in-flight word is dropped, so the PC rewinds to refetch it.
    always_comb begin
        nxt_state = state;
        if (state == ST_RUN && iw_halt) begin
            nxt_state = ST_HALT;
        end

        nxt_pc = r_pc;
        if (fetch_slot) begin
            nxt_pc = fetch_addr + ADDR_W'(1);
        end else if (iw_branch_taken) begin
            nxt_pc = iw_branch_pc;
        end else if (iw_stall && r_if) begin
            nxt_pc = r_if_pc;
        end

        nxt_if_pc = fetch_slot ? fetch_addr : r_if_pc;

        nxt_cnt = '0;
        if (data_slot && fetch_want) begin
            nxt_cnt = (r_cnt < BURST_LIMIT) ? r_cnt + 4'd1 : r_cnt;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state   <= ST_RUN;
            r_pc    <= RESET_PC;
            r_if    <= 1'b0;
            r_if_pc <= '0;
            r_dm_rd <= 1'b0;
            r_cnt   <= '0;
        end else begin
            state   <= nxt_state;
            r_pc    <= nxt_pc;
            r_if    <= fetch_slot;
            r_if_pc <= nxt_if_pc;
            r_dm_rd <= data_slot && !iw_dm_we;
            r_cnt   <= nxt_cnt;
        end
    end

endmodule
